// File: rtl/board_pkg.sv
// Shared definitions for the sudoku board memory: op encodings, default geometry
// and the width helpers every board file derives its port sizes from.
package board_pkg;

   localparam int BOX_DEF = 3;

   typedef enum logic [2:0] {
      OP_READ   = 3'd0,
      OP_LOAD   = 3'd1,
      OP_PLACE  = 3'd2,
      OP_REMOVE = 3'd3,
      OP_CHECK  = 3'd4,
      OP_CLEAR  = 3'd5
   } op_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   function automatic int side_of(input int box);
      return box * box;
   endfunction

   function automatic int cells_of(input int box);
      return side_of(box) * side_of(box);
   endfunction

   function automatic int aw_of(input int box);
      return $clog2(cells_of(box));
   endfunction

   function automatic int vw_of(input int box);
      return $clog2(side_of(box) + 1);
   endfunction

   // width of a row/column/box/digit index (0..SIDE-1)
   function automatic int uw_of(input int box);
      return $clog2(side_of(box));
   endfunction

endpackage

// File: rtl/board_mem_if.sv
// Command/response bundle of the board memory; master issues commands,
// slave (the memory) answers with a one-cycle response strobe.
interface board_mem_if import board_pkg::*; #(parameter int BOX = BOX_DEF);

   localparam int AW = aw_of(BOX);
   localparam int VW = vw_of(BOX);

   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic [2:0]    i_cmd_op;
   logic [AW-1:0] i_addr;
   logic [VW-1:0] i_digit;
   logic          i_fix;
   logic          o_rsp_valid;
   logic [VW-1:0] o_rsp_data;
   logic          o_rsp_fix;
   logic          o_rsp_conflict;
   logic          o_rsp_err;
   logic          o_busy;

   modport master (
      output i_cmd_valid, i_cmd_op, i_addr, i_digit, i_fix,
      input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_fix,
             o_rsp_conflict, o_rsp_err, o_busy
   );

   modport slave (
      input  i_cmd_valid, i_cmd_op, i_addr, i_digit, i_fix,
      output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_fix,
             o_rsp_conflict, o_rsp_err, o_busy
   );

endinterface

// File: rtl/board_unit_idx.sv
// Maps a row-major cell index to its row, column and box numbers.
// Divisors are constants, so this folds to plain combinational logic.
module board_unit_idx import board_pkg::*; #(
   parameter  int BOX  = BOX_DEF,
   localparam int SIDE = side_of(BOX),
   localparam int AW   = aw_of(BOX),
   localparam int UW   = uw_of(BOX)
) (
   input  logic [AW-1:0] i_addr,
   output logic [UW-1:0] o_row,
   output logic [UW-1:0] o_col,
   output logic [UW-1:0] o_box
);

   assign o_row = UW'(i_addr / AW'(SIDE));
   assign o_col = UW'(i_addr % AW'(SIDE));
   assign o_box = UW'((o_row / UW'(BOX)) * UW'(BOX) + o_col / UW'(BOX));

endmodule

// File: rtl/board_mem.sv
// Sudoku board store: cell values/fix bits plus row/column/box usage bitmaps,
// answering one command per cycle and sweeping the cells clear after reset.
module board_mem import board_pkg::*; #(
   parameter  int BOX   = BOX_DEF,
   localparam int SIDE  = side_of(BOX),
   localparam int CELLS = cells_of(BOX),
   localparam int AW    = aw_of(BOX),
   localparam int VW    = vw_of(BOX),
   localparam int UW    = uw_of(BOX)
) (
   input  logic        clk,
   input  logic        rst_n,
   board_mem_if.slave  bus
);

   state_e                     state_q, state_d;
   logic [AW-1:0]              cnt_q, cnt_d;
   logic [SIDE-1:0][SIDE-1:0]  row_used_q, row_used_d;
   logic [SIDE-1:0][SIDE-1:0]  col_used_q, col_used_d;
   logic [SIDE-1:0][SIDE-1:0]  box_used_q, box_used_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [VW-1:0]              rsp_data_q, rsp_data_d;
   logic                       rsp_fix_q, rsp_fix_d;
   logic                       rsp_conf_q, rsp_conf_d;
   logic                       rsp_err_q, rsp_err_d;

   // cell storage is deliberately not reset; the CLEAR sweep initialises it
   logic [VW-1:0]              cell_val_q [CELLS];
   logic                       cell_fix_q [CELLS];

   logic                       wr_en, wr_fix;
   logic [AW-1:0]              wr_addr;
   logic [VW-1:0]              wr_val;

   logic                       addr_ok, dig_ok, op_ok, bad;
   logic [AW-1:0]              addr_c;
   logic [VW-1:0]              cur_val;
   logic                       cur_fix;
   logic [UW-1:0]              row, col, box, dig_idx, old_idx;
   logic                       cnf, clr_old, set_new;

   always_comb begin
      addr_ok = 32'(bus.i_addr) < CELLS;
      dig_ok  = 32'(bus.i_digit) <= SIDE;
      op_ok   = bus.i_cmd_op <= 3'd5;
      bad     = !(addr_ok && dig_ok && op_ok);
      // out-of-range addresses are folded to cell 0 so no lookup leaves the array
      addr_c  = addr_ok ? bus.i_addr : '0;
      cur_val = cell_val_q[addr_c];
      cur_fix = cell_fix_q[addr_c];
      dig_idx = UW'(bus.i_digit - 1'b1);
      old_idx = UW'(cur_val - 1'b1);
   end

   board_unit_idx #(.BOX(BOX)) u_idx (
      .i_addr (addr_c),
      .o_row  (row),
      .o_col  (col),
      .o_box  (box)
   );

   assign cnf = (bus.i_digit != '0) &&
                (row_used_q[row][dig_idx] || col_used_q[col][dig_idx] ||
                 box_used_q[box][dig_idx]);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_used_d  = row_used_q;
      col_used_d  = col_used_q;
      box_used_d  = box_used_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_fix_d   = rsp_fix_q;
      rsp_conf_d  = rsp_conf_q;
      rsp_err_d   = rsp_err_q;
      wr_en       = 1'b0;
      wr_addr     = cnt_q;
      wr_val      = '0;
      wr_fix      = 1'b0;
      clr_old     = 1'b0;
      set_new     = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(CELLS - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: if (bus.i_cmd_valid) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_conf_d  = 1'b0;
            rsp_data_d  = addr_ok ? cur_val : '0;
            rsp_fix_d   = addr_ok && cur_fix;
            wr_addr     = addr_c;
            if (bad) begin
               rsp_err_d = 1'b1;
            end else begin
               case (bus.i_cmd_op)
                  OP_READ: ;
                  OP_LOAD: begin
                     wr_en      = 1'b1;
                     wr_val     = bus.i_digit;
                     wr_fix     = bus.i_fix;
                     clr_old    = cur_val != '0;
                     set_new    = bus.i_digit != '0;
                     rsp_data_d = bus.i_digit;
                     rsp_fix_d  = bus.i_fix;
                  end
                  OP_PLACE: begin
                     if (cur_fix || cur_val != '0 || bus.i_digit == '0) begin
                        rsp_err_d = 1'b1;
                     end else if (cnf) begin
                        rsp_conf_d = 1'b1;
                     end else begin
                        wr_en      = 1'b1;
                        wr_val     = bus.i_digit;
                        set_new    = 1'b1;
                        rsp_data_d = bus.i_digit;
                     end
                  end
                  OP_REMOVE: begin
                     if (cur_fix) begin
                        rsp_err_d = 1'b1;
                     end else begin
                        wr_en      = 1'b1;
                        clr_old    = cur_val != '0;
                        rsp_data_d = '0;
                     end
                  end
                  OP_CHECK: rsp_conf_d = cnf;
                  default: begin
                     // CLEAR: silent, outputs keep their last response
                     state_d     = ST_CLEAR;
                     cnt_d       = '0;
                     row_used_d  = '0;
                     col_used_d  = '0;
                     box_used_d  = '0;
                     rsp_valid_d = 1'b0;
                     rsp_data_d  = rsp_data_q;
                     rsp_fix_d   = rsp_fix_q;
                     rsp_conf_d  = rsp_conf_q;
                     rsp_err_d   = rsp_err_q;
                  end
               endcase
            end
            if (clr_old) begin
               row_used_d[row][old_idx] = 1'b0;
               col_used_d[col][old_idx] = 1'b0;
               box_used_d[box][old_idx] = 1'b0;
            end
            if (set_new) begin
               row_used_d[row][dig_idx] = 1'b1;
               col_used_d[col][dig_idx] = 1'b1;
               box_used_d[box][dig_idx] = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= '0;
         row_used_q  <= '0;
         col_used_q  <= '0;
         box_used_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_fix_q   <= 1'b0;
         rsp_conf_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_used_q  <= row_used_d;
         col_used_q  <= col_used_d;
         box_used_q  <= box_used_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_fix_q   <= rsp_fix_d;
         rsp_conf_q  <= rsp_conf_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         cell_val_q[wr_addr] <= wr_val;
         cell_fix_q[wr_addr] <= wr_fix;
      end
   end

   assign bus.o_cmd_ready    = state_q == ST_IDLE;
   assign bus.o_busy         = state_q == ST_CLEAR;
   assign bus.o_rsp_valid    = rsp_valid_q;
   assign bus.o_rsp_data     = rsp_data_q;
   assign bus.o_rsp_fix      = rsp_fix_q;
   assign bus.o_rsp_conflict = rsp_conf_q;
   assign bus.o_rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_board_mem.sv
// Directed scoreboard bench for board_mem: a BOX=3 instance carries the main
// sequence, a BOX=2 instance covers the small-geometry build.
module tb_board_mem;

   localparam int LIMIT = 400;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   board_mem_if #(.BOX(3)) b3 ();
   board_mem_if #(.BOX(2)) b2 ();

   board_mem #(.BOX(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   board_mem #(.BOX(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   typedef struct packed {
      logic       vld;
      logic       err;
      logic       cnf;
      logic [3:0] data;
      logic       fix;
   } rsp_t;

   typedef struct {
      rsp_t  r;
      bit    chk;
      string tag;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   function automatic rsp_t get_rsp(input int sel);
      rsp_t r;
      if (sel == 0) begin
         r.vld = b3.o_rsp_valid; r.err = b3.o_rsp_err; r.cnf = b3.o_rsp_conflict;
         r.data = b3.o_rsp_data; r.fix = b3.o_rsp_fix;
      end else begin
         r.vld = b2.o_rsp_valid; r.err = b2.o_rsp_err; r.cnf = b2.o_rsp_conflict;
         r.data = 4'(b2.o_rsp_data); r.fix = b2.o_rsp_fix;
      end
      return r;
   endfunction

   function automatic logic ready(input int sel);
      return (sel == 0) ? b3.o_cmd_ready : b2.o_cmd_ready;
   endfunction

   function automatic logic busy(input int sel);
      return (sel == 0) ? b3.o_busy : b2.o_busy;
   endfunction

   task automatic check_int(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input int op, input int addr,
                        input int dig, input logic fx);
      if (sel == 0) begin
         b3.i_cmd_valid = v; b3.i_cmd_op = 3'(op); b3.i_addr = 7'(addr);
         b3.i_digit = 4'(dig); b3.i_fix = fx;
      end else begin
         b2.i_cmd_valid = v; b2.i_cmd_op = 3'(op); b2.i_addr = 4'(addr);
         b2.i_digit = 3'(dig); b2.i_fix = fx;
      end
   endtask

   // offer a command, wait for acceptance, then compare the next-cycle response
   task automatic send(input int sel, input int op, input int addr, input int dig,
                       input logic fx, input logic e_err, input logic e_cnf,
                       input int e_data, input logic e_fix, input bit chk,
                       input string tag);
      exp_t e, x;
      rsp_t g;
      int w;
      e.r.vld = 1'b1; e.r.err = e_err; e.r.cnf = e_cnf;
      e.r.data = chk ? 4'(e_data) : 4'd0;
      e.r.fix = chk ? e_fix : 1'b0;
      e.chk = chk; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      drive(sel, 1'b1, op, addr, dig, fx);
      w = 0;
      while (!ready(sel) && w < LIMIT) begin
         @(negedge clk);
         w++;
      end
      check_int({tag, "_ready"}, int'(ready(sel)), 1);
      @(negedge clk);
      drive(sel, 1'b0, 0, 0, 0, 1'b0);
      x = sb.pop_front();
      g = get_rsp(sel);
      if (!x.chk) begin
         g.data = 4'd0;
         g.fix  = 1'b0;
      end
      tests++;
      assert (g === x.r) else begin
         fails++;
         $error("FAIL %s: got v%0b e%0b c%0b d%0d f%0b expected v%0b e%0b c%0b d%0d f%0b",
                x.tag, g.vld, g.err, g.cnf, g.data, g.fix,
                x.r.vld, x.r.err, x.r.cnf, x.r.data, x.r.fix);
      end
   endtask

   // call at a negedge where both instances are freshly in their sweep
   task automatic count_busy(input int exp3, input int exp2, input string tag);
      int n3, n2, k;
      n3 = 0; n2 = 0; k = 0;
      while ((busy(0) || busy(1)) && k < LIMIT) begin
         if (busy(0)) n3++;
         if (busy(1)) n2++;
         @(negedge clk);
         k++;
      end
      check_int({tag, "_busy3"}, n3, exp3);
      check_int({tag, "_busy2"}, n2, exp2);
      check_int({tag, "_rdy3"}, int'(ready(0)), 1);
   endtask

   initial begin
      rsp_t r;
      drive(0, 1'b0, 0, 0, 0, 1'b0);
      drive(1, 1'b0, 0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      r = get_rsp(0);
      check_int("rst_rsp", int'(r), 0);
      check_int("rst_busy", int'(busy(0)), 1);
      check_int("rst_ready", int'(ready(0)), 0);
      rst_n = 1'b1;
      count_busy(81, 16, "boot");

      // op: 0 READ 1 LOAD 2 PLACE 3 REMOVE 4 CHECK 5 CLEAR
      send(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, "rd0");
      send(0, 0, 40, 0, 0, 0, 0, 0, 0, 1, "rd40");
      send(0, 0, 80, 0, 0, 0, 0, 0, 0, 1, "rd80");
      send(0, 1,  0, 5, 1, 0, 0, 5, 1, 1, "load0");
      @(negedge clk);
      r = get_rsp(0);
      check_int("hold_vld", int'(r.vld), 0);
      check_int("hold_data", int'(r.data), 5);
      send(0, 2,  8, 5, 0, 0, 1, 0, 0, 1, "place8_row");
      send(0, 0,  8, 0, 0, 0, 0, 0, 0, 1, "rd8");
      send(0, 2, 10, 5, 0, 0, 1, 0, 0, 1, "place10_box");
      send(0, 2, 40, 7, 0, 0, 0, 7, 0, 1, "place40");
      send(0, 4, 44, 7, 0, 0, 1, 0, 0, 1, "chk44");
      send(0, 3, 40, 0, 0, 0, 0, 0, 0, 1, "rm40");
      send(0, 4, 44, 7, 0, 0, 0, 0, 0, 1, "chk44_after");
      send(0, 3,  0, 0, 0, 1, 0, 5, 1, 1, "rm_fixed");
      send(0, 2, 81, 1, 0, 1, 0, 0, 0, 0, "place81");
      send(0, 6,  3, 1, 0, 1, 0, 0, 0, 1, "op6");
      send(0, 2,  3, 10, 0, 1, 0, 0, 0, 1, "dig10");
      send(0, 2,  0, 1, 0, 1, 0, 5, 1, 1, "place_fixed");
      send(0, 2, 20, 0, 0, 1, 0, 0, 0, 1, "place_d0");
      send(0, 2, 40, 7, 0, 0, 0, 7, 0, 1, "place40b");
      send(0, 2, 40, 3, 0, 1, 0, 7, 0, 1, "place_full");
      send(0, 4, 41, 0, 0, 0, 0, 0, 0, 1, "chk_d0");
      send(0, 1, 40, 0, 0, 0, 0, 0, 0, 1, "load_zero");
      send(0, 4, 44, 7, 0, 0, 0, 0, 0, 1, "chk_after_load");
      send(0, 3, 50, 0, 0, 0, 0, 0, 0, 1, "rm_empty");
      send(0, 2, 60, 2, 0, 0, 0, 2, 0, 1, "place60");
      send(0, 4,  1, 5, 0, 0, 1, 0, 0, 1, "chk_row_pre");
      send(0, 4, 27, 5, 0, 0, 1, 0, 0, 1, "chk_col_pre");

      send(1, 2,  0, 4, 0, 0, 0, 4, 0, 1, "b2_place0");
      send(1, 4,  5, 4, 0, 0, 1, 0, 0, 1, "b2_chk5");
      send(1, 4, 10, 4, 0, 0, 0, 0, 0, 1, "b2_chk10");

      // CLEAR: no response, sweep starts; a command offered meanwhile stalls
      @(negedge clk);
      drive(0, 1'b1, 5, 0, 0, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 0, 5, 0, 1'b0);
      r = get_rsp(0);
      check_int("clr_no_rsp", int'(r.vld), 0);
      check_int("clr_busy", int'(busy(0)), 1);
      repeat (10) @(negedge clk);
      check_int("stall_ready", int'(ready(0)), 0);
      r = get_rsp(0);
      check_int("stall_no_rsp", int'(r.vld), 0);
      drive(0, 1'b0, 0, 0, 0, 1'b0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_int("rst2_busy", int'(busy(0)), 1);
      rst_n = 1'b1;
      count_busy(81, 16, "resweep");

      send(0, 4,  1, 5, 0, 0, 0, 0, 0, 1, "chk_row_post");
      send(0, 4, 27, 5, 0, 0, 0, 0, 0, 1, "chk_col_post");
      send(0, 4, 61, 2, 0, 0, 0, 0, 0, 1, "chk61_post");
      send(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, "rd0_post");
      send(0, 0, 60, 0, 0, 0, 0, 0, 0, 1, "rd60_post");
      send(1, 4,  5, 4, 0, 0, 0, 0, 0, 1, "b2_chk5_post");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
